// File: rtl/spi_flash_reader.sv
// Wishbone master that sequences SPI flash READ (0x03) transfers through the
// wb_spi register block and delivers the received bytes on a byte stream.
module spi_flash_reader #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [23:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             m_valid_o,
  output logic [7:0]       m_data_o,
  input  logic             m_ready_i,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [1:0]       adr_o,
  output logic [31:0]      dat_o,
  output logic [3:0]       sel_o,
  input  logic [31:0]      dat_i,
  input  logic             ack_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_SS_LO, S_TX, S_SETTLE, S_POLL, S_RD, S_OUT, S_SS_HI, S_DONE
  } state_t;

  state_t           r_state;
  logic [23:0]      r_addr;
  logic [LEN_W-1:0] r_cnt;
  logic [2:0]       r_hdr;
  logic             r_abt;
  logic             r_busy;
  logic             r_done;
  logic             r_aborted;
  logic             r_mvalid;
  logic [7:0]       r_mdata;
  logic             r_cyc;
  logic             r_we;
  logic [1:0]       r_adr;
  logic [31:0]      r_dat;
  logic [3:0]       r_sel;

  logic             w_bus_state;
  logic             w_req_we;
  logic [1:0]       w_req_adr;
  logic [31:0]      w_req_dat;
  logic [7:0]       w_tx_byte;
  logic             w_ack;
  logic             w_hs;
  logic             w_unused;

  // r_hdr counts bytes written: 0..3 select the header, 4 the first dummy,
  // and it saturates at 5 once a dummy has gone out.
  always_comb begin
    w_tx_byte = 8'h00;
    case (r_hdr)
      3'd0:    w_tx_byte = 8'h03;
      3'd1:    w_tx_byte = r_addr[23:16];
      3'd2:    w_tx_byte = r_addr[15:8];
      3'd3:    w_tx_byte = r_addr[7:0];
      default: w_tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_bus_state = 1'b1;
    w_req_we    = 1'b0;
    w_req_adr   = 2'd0;
    w_req_dat   = 32'h0000_0000;
    case (r_state)
      S_SS_LO: begin w_req_we = 1'b1; w_req_adr = 2'd1; end
      S_TX:    begin w_req_we = 1'b1; w_req_dat = {w_tx_byte, 24'h000000}; end
      S_POLL:  w_req_adr = 2'd1;
      S_RD:    w_req_adr = 2'd0;
      S_SS_HI: begin w_req_we = 1'b1; w_req_adr = 2'd1; w_req_dat = 32'h0100_0000; end
      default: w_bus_state = 1'b0;
    endcase
  end

  assign w_ack    = r_cyc & ack_i;
  // Stream handshake: a byte transfers on a rising edge where m_valid_o and
  // m_ready_i are both high; m_valid_o and m_data_o hold until then.
  assign w_hs     = r_mvalid & m_ready_i;
  assign w_unused = ^{dat_i[24], dat_i[23:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_addr    <= 24'h000000;
      r_cnt     <= '0;
      r_hdr     <= 3'd0;
      r_abt     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_mvalid  <= 1'b0;
      r_mdata   <= 8'h00;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= 2'd0;
      r_dat     <= 32'h0000_0000;
      r_sel     <= 4'b0000;
    end else begin
      r_done <= 1'b0;

      // A bus state launches its access when no cycle is open; the ack edge
      // closes it, which guarantees an idle cycle before the next launch.
      if (w_bus_state && !r_cyc) begin
        r_cyc <= 1'b1;
        r_we  <= w_req_we;
        r_adr <= w_req_adr;
        r_dat <= w_req_dat;
        r_sel <= 4'b1000;
      end else if (w_ack) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
        r_adr <= 2'd0;
        r_dat <= 32'h0000_0000;
        r_sel <= 4'b0000;
      end

      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_addr <= addr_i;
            r_cnt  <= len_i;
            r_hdr  <= 3'd0;
            r_abt  <= 1'b0;
            r_busy <= 1'b1;
            if (len_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SS_LO;
            end
          end
        end
        S_SS_LO: begin
          if (w_ack) begin
            r_abt   <= abort_i;
            r_state <= abort_i ? S_SS_HI : S_TX;
          end
        end
        S_TX: begin
          if (w_ack) begin
            if (r_hdr < 3'd5) r_hdr <= r_hdr + 3'd1;
            r_abt   <= abort_i;
            r_state <= abort_i ? S_SS_HI : S_SETTLE;
          end
        end
        S_SETTLE: r_state <= S_POLL;
        S_POLL: begin
          if (w_ack) begin
            if (abort_i) begin
              r_abt   <= 1'b1;
              r_state <= S_SS_HI;
            end else if (dat_i[25]) begin
              r_state <= S_POLL;
            end else begin
              r_state <= (r_hdr == 3'd5) ? S_RD : S_TX;
            end
          end
        end
        S_RD: begin
          if (w_ack) begin
            if (abort_i) begin
              r_abt   <= 1'b1;
              r_state <= S_SS_HI;
            end else begin
              r_mdata  <= dat_i[31:24];
              r_mvalid <= 1'b1;
              r_state  <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (w_hs) begin
            r_mvalid <= 1'b0;
            if (r_cnt != '0) r_cnt <= r_cnt - LEN_W'(1);
          end
          if (abort_i) begin
            r_mvalid <= 1'b0;
            r_abt    <= 1'b1;
            r_state  <= S_SS_HI;
          end else if (w_hs) begin
            r_state <= (r_cnt <= LEN_W'(1)) ? S_SS_HI : S_TX;
          end
        end
        S_SS_HI: begin
          if (w_ack) begin
            r_done    <= 1'b1;
            r_aborted <= r_abt;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy    <= 1'b0;
          r_aborted <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign aborted_o = r_aborted;
  assign m_valid_o = r_mvalid;
  assign m_data_o  = r_mdata;
  assign cyc_o     = r_cyc;
  assign stb_o     = r_cyc;
  assign we_o      = r_we;
  assign adr_o     = r_adr;
  assign dat_o     = r_dat;
  assign sel_o     = r_sel;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a wb_spi register model with an attached flash,
// a table of READ transfers, and hand-written len-0 and reset sequences.
module tb_spi_flash_reader;

  localparam int LEN_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [23:0]      addr_i = 24'h0;
  logic [LEN_W-1:0] len_i = '0;
  logic             abort_i = 1'b0;
  logic             busy_o, done_o, aborted_o, m_valid_o;
  logic [7:0]       m_data_o;
  logic             m_ready_i = 1'b1;
  logic             cyc_o, stb_o, we_o;
  logic [1:0]       adr_o;
  logic [31:0]      dat_o;
  logic [3:0]       sel_o;
  logic [31:0]      dat_i;
  logic             ack_i;

  spi_flash_reader #(.LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .addr_i(addr_i),
    .len_i(len_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o), .m_valid_o(m_valid_o), .m_data_o(m_data_o),
    .m_ready_i(m_ready_i), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h123456) return 8'hA5;
    if (a == 24'h123457) return 8'h5A;
    return a[7:0] ^ 8'h3C;
  endfunction

  // wb_spi model: ack one cycle after stb, SPI busy for 6 cycles per byte.
  logic        s_ack, s_ss;
  int          s_busy, s_idx;
  logic [7:0]  s_rx;
  logic [23:0] s_fa;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_ack <= 1'b0; s_ss <= 1'b1; s_busy <= 0; s_idx <= 0;
      s_rx <= 8'h00; s_fa <= 24'h0;
    end else begin
      s_ack <= cyc_o & stb_o & !s_ack;
      if (s_busy != 0) s_busy <= s_busy - 1;
      if (cyc_o && stb_o && !s_ack && we_o) begin
        if (adr_o == 2'd1) begin
          s_ss <= dat_o[24];
          if (!dat_o[24]) s_idx <= 0;
        end else begin
          s_busy <= 6;
          s_idx  <= s_idx + 1;
          if (s_idx == 1) s_fa[23:16] <= dat_o[31:24];
          if (s_idx == 2) s_fa[15:8]  <= dat_o[31:24];
          if (s_idx == 3) s_fa[7:0]   <= dat_o[31:24];
          s_rx <= (s_idx >= 4) ? flash_byte(s_fa + 24'(s_idx - 4)) : 8'hFF;
        end
      end
    end
  end

  assign ack_i = s_ack;
  assign dat_i = (adr_o == 2'd1) ? {6'b0, (s_busy != 0), s_ss, 24'h0}
                                 : {((s_busy != 0) ? 8'hEE : s_rx), 24'h0};

  // Monitor and scoreboard state
  logic [31:0] w0_q[$];
  logic [31:0] w1_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] exp_w0[$];
  int          done_cnt, cyc_cnt, proto_err;
  logic        ab_seen;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk_i) begin
    if (cyc_o) cyc_cnt++;
    if (cyc_o !== stb_o) proto_err++;
    if (cyc_o && sel_o != 4'b1000) proto_err++;
    if (!cyc_o && sel_o != 4'b0000) proto_err++;
    if (aborted_o && !done_o) proto_err++;
    if (cyc_o && ack_i && we_o && adr_o == 2'd0) w0_q.push_back(dat_o);
    if (cyc_o && ack_i && we_o && adr_o == 2'd1) w1_q.push_back(dat_o);
    if (m_valid_o && m_ready_i) got_q.push_back(m_data_o);
    if (done_o) begin
      done_cnt++;
      ab_seen = aborted_o;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    w0_q.delete(); w1_q.delete(); got_q.delete();
    done_cnt = 0; cyc_cnt = 0; proto_err = 0; ab_seen = 1'b0;
  endtask

  typedef struct {
    logic [23:0] addr;
    int          len;
    int          stall;
    int          abort_byte;
    int          ign_start;
    int          exp_bytes;
    logic        exp_abort;
    int          exp_w0;
    logic [7:0]  exp_first;
  } vec_t;

  task automatic run_txn(input int idx, input vec_t v);
    int         stall_left, ign_state, w0_hold, stall_err;
    logic       stalled, armed;
    logic [7:0] held;
    string      p;
    p = $sformatf("v%0d_", idx);
    clear_mon();
    exp_q.delete(); exp_w0.delete();
    for (int i = 0; i < v.exp_bytes; i++) exp_q.push_back(flash_byte(v.addr + 24'(i)));
    exp_w0.push_back(32'h0300_0000);
    exp_w0.push_back({v.addr[23:16], 24'h0});
    exp_w0.push_back({v.addr[15:8], 24'h0});
    exp_w0.push_back({v.addr[7:0], 24'h0});
    for (int i = 4; i < v.exp_w0; i++) exp_w0.push_back(32'h0);
    stalled = 1'b0; armed = 1'b0; stall_left = 0; ign_state = 0;
    w0_hold = 0; stall_err = 0; held = 8'h00;
    m_ready_i = (v.stall == 0);
    @(posedge clk_i); #1;
    start_i = 1'b1; addr_i = v.addr; len_i = LEN_W'(v.len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
      @(negedge clk_i);
      if (v.ign_start != 0 && ign_state == 0 && w0_q.size() == 1) begin
        start_i = 1'b1; addr_i = 24'hABCDEF; len_i = LEN_W'(5); ign_state = 1;
      end else if (ign_state == 1) begin
        start_i = 1'b0; ign_state = 2;
      end
      if (v.abort_byte > 0 && !armed && w0_q.size() == 4 + v.abort_byte &&
          cyc_o && !we_o && adr_o == 2'd1) begin
        abort_i = 1'b1; armed = 1'b1;
      end
      if (v.stall > 0 && !stalled && m_valid_o) begin
        stalled = 1'b1; held = m_data_o; w0_hold = w0_q.size(); stall_left = v.stall;
      end else if (stalled && stall_left > 0) begin
        if (!m_valid_o || m_data_o !== held) stall_err++;
        stall_left--;
        if (stall_left == 0) begin
          chk({p, "stall_no_adr0_write"}, w0_q.size(), w0_hold);
          @(posedge clk_i); #1;
          m_ready_i = 1'b1;
        end
      end
    end
    repeat (4) @(negedge clk_i);
    abort_i = 1'b0;
    chk({p, "done_count"}, done_cnt, 1);
    chk({p, "aborted"}, ab_seen, v.exp_abort);
    chk({p, "busy_after"}, busy_o, 0);
    chk({p, "proto"}, proto_err, 0);
    chk({p, "byte_count"}, got_q.size(), v.exp_bytes);
    if (got_q.size() > 0) chk({p, "first_byte"}, got_q[0], v.exp_first);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%sbyte%0d", p, i), got_q[i], exp_q[i]);
    chk({p, "adr0_write_count"}, w0_q.size(), v.exp_w0);
    for (int i = 0; i < w0_q.size() && i < exp_w0.size(); i++)
      chk($sformatf("%sadr0_wr%0d", p, i), w0_q[i], exp_w0[i]);
    chk({p, "adr1_write_count"}, w1_q.size(), 2);
    if (w1_q.size() == 2) begin
      chk({p, "ss_low_write"}, w1_q[0], 32'h0000_0000);
      chk({p, "ss_high_write"}, w1_q[1], 32'h0100_0000);
    end
    if (v.stall > 0) begin
      chk({p, "stall_seen"}, stalled, 1);
      chk({p, "stall_hold"}, stall_err, 0);
    end
    if (v.abort_byte > 0) chk({p, "abort_armed"}, armed, 1);
    m_ready_i = 1'b1;
  endtask

  vec_t vecs[5];
  vec_t v_after_rst;

  initial begin
    vecs[0] = '{24'h123456, 2, 0,  0, 0, 2, 1'b0, 6, 8'hA5};
    vecs[1] = '{24'h000100, 3, 20, 0, 0, 3, 1'b0, 7, 8'h3C};
    vecs[2] = '{24'h123456, 8, 0,  3, 0, 2, 1'b1, 7, 8'hA5};
    vecs[3] = '{24'hFFFFFE, 1, 0,  0, 0, 1, 1'b0, 5, 8'hC2};
    vecs[4] = '{24'h00ABCD, 2, 0,  0, 1, 2, 1'b0, 6, 8'hF1};
    v_after_rst = '{24'h000042, 1, 0, 0, 0, 1, 1'b0, 5, 8'h7E};

    clear_mon();
    repeat (3) @(negedge clk_i);
    chk("reset_ctrl_outputs",
        {19'h0, cyc_o, stb_o, we_o, adr_o, sel_o, busy_o, done_o, aborted_o, m_valid_o}, 0);
    chk("reset_dat_o", dat_o, 0);
    chk("reset_m_data", {24'h0, m_data_o}, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    for (int i = 0; i < 5; i++) run_txn(i, vecs[i]);

    // len 0: done the cycle after start, busy for that cycle only, no bus traffic
    clear_mon();
    @(posedge clk_i); #1;
    start_i = 1'b1; addr_i = 24'h777777; len_i = '0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("len0_done", done_o, 1);
    chk("len0_busy", busy_o, 1);
    chk("len0_aborted", aborted_o, 0);
    @(negedge clk_i);
    chk("len0_done_clear", done_o, 0);
    chk("len0_busy_clear", busy_o, 0);
    repeat (5) @(negedge clk_i);
    chk("len0_no_cyc", cyc_cnt, 0);
    chk("len0_done_count", done_cnt, 1);

    // reset while a TX write is on the bus
    clear_mon();
    @(posedge clk_i); #1;
    start_i = 1'b1; addr_i = 24'h123456; len_i = LEN_W'(4);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int n = 0; n < 200 && !(cyc_o && we_o && adr_o == 2'd0); n++) @(negedge clk_i);
    chk("rst_reached_tx", {30'h0, cyc_o && we_o, adr_o == 2'd0}, 3);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_async_ctrl",
        {19'h0, cyc_o, stb_o, we_o, adr_o, sel_o, busy_o, done_o, aborted_o, m_valid_o}, 0);
    chk("rst_async_dat", dat_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    run_txn(5, v_after_rst);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
